// File: rtl/dma_address_count_bank_pkg.sv
// dma_address_count_bank_pkg: mode-bit layout and channel-select decode shared by the DMA bank.
package dma_address_count_bank_pkg;
    localparam int MODE_AUTOINIT = 0;
    localparam int MODE_DECREMENT = 1;
    localparam int MODE_HOLD = 2;
    localparam int MODE_BITS = 3;
    localparam int MAX_CHANNELS = 8;
    function automatic logic [2:0] onehot_to_index(input logic [MAX_CHANNELS-1:0] onehot);
        logic [2:0] index;
        index = '0;
        for (int i = MAX_CHANNELS - 1; i >= 0; i--)
            if (onehot[i]) index = 3'(i);
        return index;
    endfunction
endpackage

// File: rtl/dma_channel_registers.sv
// dma_channel_registers: base/current address, base/current word count and page for one channel.
module dma_channel_registers
    import dma_address_count_bank_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int COUNT_WIDTH = 16,
    parameter int PAGE_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   master_clear_i,
    input  logic [7:0]             data_i,
    input  logic                   byte_pointer_i,
    input  logic                   write_address_i,
    input  logic                   write_count_i,
    input  logic                   write_page_i,
    input  logic                   step_i,
    input  logic                   reload_i,
    input  logic [MODE_BITS-1:0]   mode_i,
    output logic [ADDR_WIDTH-1:0]  current_address_o,
    output logic [ADDR_WIDTH-1:0]  next_address_o,
    output logic [COUNT_WIDTH-1:0] current_count_o,
    output logic [PAGE_WIDTH-1:0]  page_o,
    output logic                   terminal_o
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = 1;
    logic [ADDR_WIDTH-1:0] base_address_q, base_address_d, current_address_q, current_address_d, stepped_address;
    logic [COUNT_WIDTH-1:0] base_count_q, base_count_d, current_count_q, current_count_d;
    logic [PAGE_WIDTH-1:0] page_q, page_d;
    logic cpu_write, advance, autoinit;
    // A CPU write beats reload, which beats a step; autoinit replaces the stepped values at terminal count.
    always_comb begin
        cpu_write = write_address_i | write_count_i | write_page_i;
        advance = step_i & ~reload_i & ~cpu_write;
        terminal_o = advance & (current_count_q == '0);
        autoinit = terminal_o & mode_i[MODE_AUTOINIT];
        stepped_address = mode_i[MODE_HOLD] ? current_address_q :
                          mode_i[MODE_DECREMENT] ? current_address_q - ADDR_ONE : current_address_q + ADDR_ONE;
        base_address_d = !write_address_i ? base_address_q : byte_pointer_i ?
                         {data_i[ADDR_WIDTH-9:0], base_address_q[7:0]} : {base_address_q[ADDR_WIDTH-1:8], data_i};
        base_count_d = !write_count_i ? base_count_q : byte_pointer_i ?
                       {data_i[COUNT_WIDTH-9:0], base_count_q[7:0]} : {base_count_q[COUNT_WIDTH-1:8], data_i};
        current_address_d = write_address_i ? (byte_pointer_i ?
                            {data_i[ADDR_WIDTH-9:0], current_address_q[7:0]} : {current_address_q[ADDR_WIDTH-1:8], data_i}) :
                            cpu_write ? current_address_q :
                            (reload_i | autoinit) ? base_address_q :
                            advance ? stepped_address : current_address_q;
        current_count_d = write_count_i ? (byte_pointer_i ?
                          {data_i[COUNT_WIDTH-9:0], current_count_q[7:0]} : {current_count_q[COUNT_WIDTH-1:8], data_i}) :
                          cpu_write ? current_count_q :
                          (reload_i | autoinit) ? base_count_q :
                          advance ? current_count_q - COUNT_ONE : current_count_q;
        page_d = write_page_i ? data_i[PAGE_WIDTH-1:0] : page_q;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_address_q <= '0;
            current_address_q <= '0;
            base_count_q <= '0;
            current_count_q <= '0;
            page_q <= '0;
        end else begin
            base_address_q <= master_clear_i ? '0 : base_address_d;
            current_address_q <= master_clear_i ? '0 : current_address_d;
            base_count_q <= master_clear_i ? '0 : base_count_d;
            current_count_q <= master_clear_i ? '0 : current_count_d;
            page_q <= master_clear_i ? '0 : page_d;
        end
    end
    assign current_address_o = current_address_q;
    assign next_address_o = current_address_d;
    assign current_count_o = current_count_q;
    assign page_o = page_q;
endmodule

// File: rtl/dma_address_count_bank.sv
// dma_address_count_bank: per-channel DMA address/count registers with CPU byte access and
// a shared byte pointer, stepping the one-hot selected channel.
module dma_address_count_bank
    import dma_address_count_bank_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int COUNT_WIDTH = 16,
    parameter int PAGE_WIDTH = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [7:0]                       data_in,
    output logic [7:0]                       data_out,
    input  logic [CHANNELS-1:0]              write_address,
    input  logic [CHANNELS-1:0]              write_count,
    input  logic [CHANNELS-1:0]              write_page,
    input  logic [CHANNELS-1:0]              read_address,
    input  logic [CHANNELS-1:0]              read_count,
    input  logic                             clear_byte_pointer,
    input  logic                             master_clear,
    input  logic [CHANNELS-1:0]              channel_select,
    input  logic                             step,
    input  logic                             reload,
    input  logic [CHANNELS-1:0]              mode_autoinit,
    input  logic [CHANNELS-1:0]              mode_decrement,
    input  logic [CHANNELS-1:0]              mode_hold,
    output logic [PAGE_WIDTH+ADDR_WIDTH-1:0] transfer_address,
    output logic                             high_address_update,
    output logic                             terminal_count,
    output logic                             byte_pointer
);
    logic [ADDR_WIDTH-1:0] current_address [CHANNELS];
    logic [ADDR_WIDTH-1:0] next_address [CHANNELS];
    logic [COUNT_WIDTH-1:0] current_count [CHANNELS];
    logic [PAGE_WIDTH-1:0] page [CHANNELS];
    logic [MODE_BITS-1:0] mode [CHANNELS];
    logic [CHANNELS-1:0] terminal;
    logic [2:0] sel_index;
    logic [ADDR_WIDTH-1:0] sel_address, sel_next_address;
    logic [PAGE_WIDTH-1:0] sel_page;
    logic [PAGE_WIDTH+ADDR_WIDTH-1:0] transfer_address_q;
    logic byte_pointer_q, byte_pointer_d, terminal_count_q;
    for (genvar c = 0; c < CHANNELS; c++) begin : g_channel
        dma_channel_registers #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .COUNT_WIDTH(COUNT_WIDTH),
            .PAGE_WIDTH(PAGE_WIDTH)
        ) u_channel (
            .clock(clock),
            .reset(reset),
            .master_clear_i(master_clear),
            .data_i(data_in),
            .byte_pointer_i(byte_pointer_q),
            .write_address_i(write_address[c]),
            .write_count_i(write_count[c]),
            .write_page_i(write_page[c]),
            .step_i(step & channel_select[c]),
            .reload_i(reload & channel_select[c]),
            .mode_i(mode[c]),
            .current_address_o(current_address[c]),
            .next_address_o(next_address[c]),
            .current_count_o(current_count[c]),
            .page_o(page[c]),
            .terminal_o(terminal[c])
        );
    end
    // Read mux scans high to low so the lowest index wins, with address scanned last to beat count.
    always_comb begin
        data_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mode[i] = '0;
            mode[i][MODE_AUTOINIT] = mode_autoinit[i];
            mode[i][MODE_DECREMENT] = mode_decrement[i];
            mode[i][MODE_HOLD] = mode_hold[i];
        end
        for (int i = CHANNELS - 1; i >= 0; i--)
            if (read_count[i]) data_out = byte_pointer_q ? 8'(current_count[i] >> 8) : current_count[i][7:0];
        for (int i = CHANNELS - 1; i >= 0; i--)
            if (read_address[i]) data_out = byte_pointer_q ? 8'(current_address[i] >> 8) : current_address[i][7:0];
        sel_index = onehot_to_index(8'(channel_select));
        sel_address = '0;
        sel_next_address = '0;
        sel_page = '0;
        for (int i = 0; i < CHANNELS; i++)
            if ((|channel_select) && 3'(i) == sel_index) begin
                sel_address = current_address[i];
                sel_next_address = next_address[i];
                sel_page = page[i];
            end
        high_address_update = step & (|channel_select) & (sel_next_address[8] != transfer_address_q[8]);
        byte_pointer_d = clear_byte_pointer ? 1'b0 :
                         (|{write_address, write_count, read_address, read_count}) ? ~byte_pointer_q : byte_pointer_q;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_pointer_q <= 1'b0;
            terminal_count_q <= 1'b0;
            transfer_address_q <= '0;
        end else if (master_clear) begin
            byte_pointer_q <= 1'b0;
            terminal_count_q <= 1'b0;
            transfer_address_q <= '0;
        end else begin
            byte_pointer_q <= byte_pointer_d;
            terminal_count_q <= |terminal;
            transfer_address_q <= {sel_page, sel_address};
        end
    end
    assign transfer_address = transfer_address_q;
    assign terminal_count = terminal_count_q;
    assign byte_pointer = byte_pointer_q;
endmodule

// File: tb/tb_dma_address_count_bank.sv
// tb_dma_address_count_bank: table-driven register access plus hand-written stepping, terminal-count,
// reload, write-versus-step and reset sequences, scored through an expected-value queue.
module tb_dma_address_count_bank;
    localparam int CH = 4;
    localparam int CH8 = 8;
    logic clock;
    logic reset, clear_byte_pointer, master_clear, step, reload;
    logic [7:0] data_in, data_out;
    logic [CH-1:0] write_address, write_count, write_page, read_address, read_count;
    logic [CH-1:0] channel_select, mode_autoinit, mode_decrement, mode_hold;
    logic [23:0] transfer_address;
    logic high_address_update, terminal_count, byte_pointer;
    logic reset8, clear8, mclr8, step8, reload8;
    logic [7:0] din8, dout8;
    logic [CH8-1:0] wa8, wc8, wp8, ra8, rc8, sel8, mauto8, mdec8, mhold8;
    logic [19:0] xfer8;
    logic hua8, tc8, bp8;
    logic [31:0] exp_q [$];
    int checks = 0, errors = 0;

    typedef struct {
        bit          is_count;
        int          ch;
        logic [15:0] value;
        logic [7:0]  exp_lo;
        logic [7:0]  exp_hi;
    } vec_t;
    vec_t vecs [6];

    dma_address_count_bank dut (
        .clock(clock), .reset(reset), .data_in(data_in), .data_out(data_out),
        .write_address(write_address), .write_count(write_count), .write_page(write_page),
        .read_address(read_address), .read_count(read_count),
        .clear_byte_pointer(clear_byte_pointer), .master_clear(master_clear),
        .channel_select(channel_select), .step(step), .reload(reload),
        .mode_autoinit(mode_autoinit), .mode_decrement(mode_decrement), .mode_hold(mode_hold),
        .transfer_address(transfer_address), .high_address_update(high_address_update),
        .terminal_count(terminal_count), .byte_pointer(byte_pointer)
    );

    dma_address_count_bank #(.CHANNELS(8), .ADDR_WIDTH(12)) dut8 (
        .clock(clock), .reset(reset8), .data_in(din8), .data_out(dout8),
        .write_address(wa8), .write_count(wc8), .write_page(wp8),
        .read_address(ra8), .read_count(rc8),
        .clear_byte_pointer(clear8), .master_clear(mclr8),
        .channel_select(sel8), .step(step8), .reload(reload8),
        .mode_autoinit(mauto8), .mode_decrement(mdec8), .mode_hold(mhold8),
        .transfer_address(xfer8), .high_address_update(hua8),
        .terminal_count(tc8), .byte_pointer(bp8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic expect_v(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] actual);
        logic [31:0] expected;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got %h, no expected value queued", name, actual);
        end else begin
            expected = exp_q.pop_front();
            if (actual !== expected) begin
                errors++;
                $display("FAIL %s: got %h expected %h", name, actual, expected);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_bp();
        clear_byte_pointer = 1'b1;
        tick();
        clear_byte_pointer = 1'b0;
    endtask

    task automatic wr(input bit is_count, input int ch, input logic [7:0] d);
        data_in = d;
        if (is_count) write_count[ch] = 1'b1;
        else write_address[ch] = 1'b1;
        tick();
        write_count = '0;
        write_address = '0;
    endtask

    task automatic wr16(input bit is_count, input int ch, input logic [15:0] v);
        clear_bp();
        wr(is_count, ch, v[7:0]);
        wr(is_count, ch, v[15:8]);
    endtask

    task automatic rd16(input bit is_count, input int ch, output logic [15:0] v);
        clear_bp();
        if (is_count) read_count[ch] = 1'b1;
        else read_address[ch] = 1'b1;
        #1 v[7:0] = data_out;
        tick();
        #1 v[15:8] = data_out;
        tick();
        read_count = '0;
        read_address = '0;
    endtask

    initial begin
        logic [15:0] v;
        vecs[0] = '{1'b1, 0, 16'hBEEF, 8'hEF, 8'hBE};
        vecs[1] = '{1'b0, 2, 16'h0F0E, 8'h0E, 8'h0F};
        vecs[2] = '{1'b0, 3, 16'hA55A, 8'h5A, 8'hA5};
        vecs[3] = '{1'b1, 2, 16'h0001, 8'h01, 8'h00};
        vecs[4] = '{1'b0, 0, 16'hFFFF, 8'hFF, 8'hFF};
        vecs[5] = '{1'b1, 3, 16'h8000, 8'h00, 8'h80};
        reset = 1'b1; clear_byte_pointer = 0; master_clear = 0; step = 0; reload = 0; data_in = '0;
        write_address = '0; write_count = '0; write_page = '0; read_address = '0; read_count = '0;
        channel_select = '0; mode_autoinit = '0; mode_decrement = '0; mode_hold = '0;
        reset8 = 1'b1; clear8 = 0; mclr8 = 0; step8 = 0; reload8 = 0; din8 = '0;
        wa8 = '0; wc8 = '0; wp8 = '0; ra8 = '0; rc8 = '0; sel8 = '0; mauto8 = '0; mdec8 = '0; mhold8 = '0;
        repeat (2) tick();
        expect_v(0); check("rst_xfer", 32'(transfer_address));
        expect_v(0); check("rst_tc", 32'(terminal_count));
        expect_v(0); check("rst_bp", 32'(byte_pointer));
        expect_v(0); check("rst_dout", 32'(data_out));
        expect_v(0); check("rst_hua", 32'(high_address_update));
        reset = 1'b0;
        reset8 = 1'b0;
        tick();

        // Channel 1 address: byte-wise write then byte-wise read back.
        wr(1'b0, 1, 8'h34);
        expect_v(1); check("wr_lo_bp", 32'(byte_pointer));
        wr(1'b0, 1, 8'h12);
        expect_v(0); check("wr_hi_bp", 32'(byte_pointer));
        read_address[1] = 1'b1;
        expect_v(32'h34); #1 check("rd_lo", 32'(data_out));
        tick();
        expect_v(32'h12); #1 check("rd_hi", 32'(data_out));
        tick();
        read_address = '0;
        expect_v(0); check("rd_bp", 32'(byte_pointer));

        for (int i = 0; i < 6; i++) begin
            wr16(vecs[i].is_count, vecs[i].ch, vecs[i].value);
            expect_v(32'(vecs[i].exp_lo));
            expect_v(32'(vecs[i].exp_hi));
            rd16(vecs[i].is_count, vecs[i].ch, v);
            check($sformatf("tbl%0d_lo", i), 32'(v[7:0]));
            check($sformatf("tbl%0d_hi", i), 32'(v[15:8]));
        end

        // Read priority: lowest index first, address before count; idle bus reads 0.
        clear_bp();
        read_address = 4'b1010;
        expect_v(32'h34); #1 check("prio_index", 32'(data_out));
        tick();
        read_address = 4'b1000;
        read_count = 4'b0001;
        expect_v(32'hA5); #1 check("prio_addr", 32'(data_out));
        tick();
        read_address = '0;
        read_count = '0;
        expect_v(0); #1 check("idle_dout", 32'(data_out));

        // Increment across a 256-word boundary on channel 2 with page 0x5A.
        wr16(1'b1, 2, 16'h0002);
        wr16(1'b0, 2, 16'h00FF);
        data_in = 8'h5A;
        write_page[2] = 1'b1;
        tick();
        write_page = '0;
        channel_select = 4'b0100;
        tick();
        expect_v(32'h5A00FF); check("xfer_pre", 32'(transfer_address));
        step = 1'b1;
        expect_v(1); #1 check("hua_cross", 32'(high_address_update));
        tick();
        step = 1'b0;
        expect_v(0); check("tc_nonzero", 32'(terminal_count));
        tick();
        expect_v(32'h5A0100); check("xfer_post", 32'(transfer_address));
        expect_v(1); rd16(1'b1, 2, v); check("cnt_after_step", 32'(v));
        step = 1'b1;
        expect_v(0); #1 check("hua_nocross", 32'(high_address_update));
        tick();
        step = 1'b0;

        // Autoinit on channel 0: five steps drain count 5, the sixth reloads from base.
        mode_autoinit = 4'b0001;
        wr16(1'b0, 0, 16'h1000);
        wr16(1'b1, 0, 16'h0005);
        channel_select = 4'b0001;
        step = 1'b1;
        repeat (5) tick();
        expect_v(0); check("tc_before_zero", 32'(terminal_count));
        tick();
        step = 1'b0;
        expect_v(1); check("tc_auto", 32'(terminal_count));
        tick();
        expect_v(0); check("tc_one_cycle", 32'(terminal_count));
        expect_v(32'h1000); rd16(1'b0, 0, v); check("auto_addr", 32'(v));
        expect_v(5); rd16(1'b1, 0, v); check("auto_cnt", 32'(v));
        mode_autoinit = '0;

        // Decrement wrap on channel 3 without autoinit.
        mode_decrement = 4'b1000;
        wr16(1'b0, 3, 16'h0000);
        wr16(1'b1, 3, 16'h0000);
        channel_select = 4'b1000;
        step = 1'b1;
        tick();
        step = 1'b0;
        expect_v(1); check("tc_wrap", 32'(terminal_count));
        expect_v(32'hFFFF); rd16(1'b1, 3, v); check("wrap_cnt", 32'(v));
        expect_v(32'hFFFF); rd16(1'b0, 3, v); check("wrap_addr", 32'(v));

        // Reload with step: reload wins and no terminal count even at count 0.
        step = 1'b1;
        reload = 1'b1;
        repeat (2) tick();
        step = 1'b0;
        reload = 1'b0;
        expect_v(0); check("tc_reload", 32'(terminal_count));
        expect_v(0); rd16(1'b1, 3, v); check("reload_cnt", 32'(v));
        expect_v(0); rd16(1'b0, 3, v); check("reload_addr", 32'(v));
        mode_decrement = '0;

        // CPU write and step to channel 1 together: the write lands, no step.
        wr16(1'b1, 1, 16'h0010);
        channel_select = 4'b0010;
        clear_bp();
        data_in = 8'h77;
        write_address[1] = 1'b1;
        step = 1'b1;
        tick();
        write_address = '0;
        step = 1'b0;
        expect_v(0); check("tc_wrstep", 32'(terminal_count));
        expect_v(32'h1277); rd16(1'b0, 1, v); check("wrstep_addr", 32'(v));
        expect_v(32'h0010); rd16(1'b1, 1, v); check("wrstep_cnt", 32'(v));

        // Master clear zeroes state.
        wr(1'b0, 2, 8'h01);
        master_clear = 1'b1;
        tick();
        master_clear = 1'b0;
        expect_v(0); check("mclr_bp", 32'(byte_pointer));
        expect_v(0); check("mclr_xfer", 32'(transfer_address));
        expect_v(0); rd16(1'b0, 1, v); check("mclr_addr", 32'(v));

        // 8-channel, 12-bit instance: reset asserted in the middle of a step.
        din8 = 8'hAB;
        wa8[5] = 1'b1;
        tick();
        din8 = 8'h0C;
        tick();
        wa8 = '0;
        din8 = 8'h03;
        wp8[5] = 1'b1;
        tick();
        wp8 = '0;
        sel8 = 8'b0010_0000;
        tick();
        expect_v(32'h3CAB); check("w8_xfer", 32'(xfer8));
        step8 = 1'b1;
        ra8[5] = 1'b1;
        tick();
        #2 reset8 = 1'b1;
        #1;
        expect_v(0); check("w8_rst_xfer", 32'(xfer8));
        expect_v(0); check("w8_rst_tc", 32'(tc8));
        expect_v(0); check("w8_rst_bp", 32'(bp8));
        expect_v(0); check("w8_rst_dout", 32'(dout8));
        expect_v(0); check("w8_rst_hua", 32'(hua8));
        step8 = 1'b0;
        ra8 = '0;
        tick();
        reset8 = 1'b0;
        tick();
        ra8[5] = 1'b1;
        expect_v(0); #1 check("w8_addr_lo", 32'(dout8));
        tick();
        expect_v(0); #1 check("w8_addr_hi", 32'(dout8));
        tick();
        ra8 = '0;
        expect_v(0); check("w8_xfer_after", 32'(xfer8));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dma_address_count_bank.md
DMA_ADDRESS_COUNT_BANK -- requirements
Module: dma_address_count_bank

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, the number of DMA channels (2..8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16, the current/base address width (9..16).
REQ-003 The block SHALL have parameter COUNT_WIDTH, default 16, the current/base word-count width (9..16).
REQ-004 The block SHALL have parameter PAGE_WIDTH, default 8, the per-channel page register width (1..8).
REQ-005 The block SHALL have port clock, input, 1, the system clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, the reset; asynchronous, active-high.
REQ-007 The block SHALL have ports data_in (input, 8, CPU write byte) and data_out (output, 8, CPU read byte, combinational).
REQ-008 The block SHALL have ports write_address, write_count and write_page (input, CHANNELS each, one-hot single-cycle write strobes).
REQ-009 The block SHALL have ports read_address and read_count (input, CHANNELS each, one-hot single-cycle read strobes).
REQ-010 The block SHALL have ports clear_byte_pointer and master_clear (input, 1 each, single-cycle commands).
REQ-011 The block SHALL have ports channel_select (input, CHANNELS, one-hot active channel), step (input, 1, advance the selected channel by one word) and reload (input, 1, copy base to current).
REQ-012 The block SHALL have ports mode_autoinit, mode_decrement and mode_hold (input, CHANNELS each, per-channel mode bits).
REQ-013 The block SHALL have ports transfer_address (output, PAGE_WIDTH+ADDR_WIDTH, {page, current address} of the selected channel), high_address_update (output, 1), terminal_count (output, 1) and byte_pointer (output, 1).

Function
REQ-014 Each channel SHALL hold base_address, current_address, base_count, current_count and a page register.
REQ-015 An address/count write strobe SHALL load data_in into bits [7:0] of both base and current when byte_pointer=0, or bits [W-1:8] when byte_pointer=1; byte_pointer SHALL then toggle.
REQ-016 A page write SHALL load data_in[PAGE_WIDTH-1:0] in one cycle without affecting byte_pointer.
REQ-017 A read strobe SHALL place the low or high byte of the current register on data_out per byte_pointer, with unused high bits read as 0; byte_pointer SHALL toggle on the edge ending the strobe. data_out SHALL be 0 with no read strobe; lowest-index address strobe wins, then count.
REQ-018 Step on the selected channel SHALL take effect on the same edge: current_count decrements by 1 (wrapping from 0 to all-ones); current_address does +1, or -1 if mode_decrement, or is held if mode_hold (hold has priority); address wraps modulo 2^ADDR_WIDTH; page is never modified.
REQ-019 Terminal count: a step with current_count=0 SHALL drive terminal_count high for exactly the following cycle.
REQ-020 Autoinit: at terminal count with mode_autoinit=1, current_address and current_count SHALL load from base instead of the stepped values.
REQ-021 Reload SHALL copy base to current for the selected channel; if asserted with step, reload wins and terminal_count is not set.
REQ-022 transfer_address SHALL register every cycle from the selected channel's pre-update state; high_address_update SHALL be combinational and high when step is asserted and the next address bit 8 differs from transfer_address bit 8.
REQ-023 A CPU write to a channel in the same cycle as its step SHALL win, with the step ignored for that channel.
REQ-024 Priority SHALL be master_clear > clear_byte_pointer > write toggle > read toggle.

Reset
REQ-025 reset or master_clear SHALL zero all registers, byte_pointer, terminal_count and transfer_address; reset mid-step SHALL abort the step.

Structure
REQ-026 The one-hot-to-index function and the mode-bit constants SHALL live in a shared dma package.
REQ-027 The block SHALL instantiate one sub-module, dma_channel_registers, per channel via generate.

Verification
REQ-028 The bench SHALL write 0x34 then 0x12 to channel 1 address, read it back, and require 0x34, 0x12, byte_pointer=0.
REQ-029 The bench SHALL step with count=2, increment and address 0x00FF, and require address 0x0100, high_address_update=1 and count=1.
REQ-030 The bench SHALL set count=0 with autoinit, base address 0x1000 and base count 5, step, and require terminal_count for one cycle, address 0x1000 and count 5.
REQ-031 The bench SHALL step with count=0, decrement, no autoinit and address 0x0000, and require count 0xFFFF, address 0xFFFF and terminal_count=1.
REQ-032 The bench SHALL assert a write and a step to the same channel together and require the written byte with no decrement.
REQ-033 The bench SHALL assert reset mid-sequence with CHANNELS=8, ADDR_WIDTH=12 and require all outputs 0.
